// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings (single-sourced with the decode-side
// ALU control unit), execute-stage FSM states and op classification helpers.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of the execute-stage ALU: request side carries the
// op code and operands, response side the registered result and zero flag.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [3:0]      alu_ctrl_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            zero_o;

  // Producer/consumer side driving requests and accepting results.
  modport master (
    output in_valid_i, alu_ctrl_i, op_a_i, op_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o
  );

  // The ALU itself.
  modport slave (
    input  in_valid_i, alu_ctrl_i, op_a_i, op_b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter for SLL/SRL/SRA. Loaded by start_i, it asserts
// done_o during its last step while result_o presents the final shifted value.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [3:0]         op_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o
);

  logic [XLEN-1:0]    sh_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [3:0]         op_q;
  logic [XLEN-1:0]    sh_step;
  logic               fill_bit;

  assign fill_bit = (op_q == ALU_SRA) & sh_q[XLEN-1];
  assign sh_step  = (op_q == ALU_SLL) ? {sh_q[XLEN-2:0], 1'b0}
                                      : {fill_bit, sh_q[XLEN-1:1]};

  // start_i is only raised with a nonzero shift amount, so cnt_q==1 marks the last step.
  assign done_o   = (cnt_q == SHAMT_W'(1));
  assign result_o = sh_step;

  // NOTE: the data register is reset along with the counter so no stale operand
  // from an aborted shift survives reset; it is a single register, not a memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      cnt_q <= '0;
      op_q  <= ALU_SLL;
    end else if (start_i) begin
      sh_q  <= data_i;
      cnt_q <= shamt_i;
      op_q  <= op_i;
    end else if (cnt_q != '0) begin
      sh_q  <= sh_step;
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and registered result.
// Build option ALU_FAST_SHIFT_EN: barrel shifter, every op completes in one cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  alu_exec_unit_if.slave bus
);

  alu_state_e         state_q, state_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               accept;
  logic [SHAMT_W-1:0] shamt;

  assign accept = bus.in_valid_i & (state_q == ST_IDLE);
  assign shamt  = bus.op_b_i[SHAMT_W-1:0];

  // In the iterative build shifts return operand A here: that is both the
  // shamt==0 result and the value loaded ahead of the serial shift.
  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0]      op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [SHAMT_W-1:0] sh;
    sh = b[SHAMT_W-1:0];
    case (op)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SUB:  return a - b;
      ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return XLEN'($signed(a) >>> sh);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: return (sh == '0) ? a : a;
`endif
      default:  return a + b;
    endcase
  endfunction

`ifndef ALU_FAST_SHIFT_EN
  logic            sh_start;
  logic            sh_done;
  logic [XLEN-1:0] sh_result;

  assign sh_start = accept & is_shift(bus.alu_ctrl_i) & (shamt != '0);

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (sh_start),
    .op_i     (bus.alu_ctrl_i),
    .data_i   (bus.op_a_i),
    .shamt_i  (shamt),
    .done_o   (sh_done),
    .result_o (sh_result)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
          if (sh_start) state_d = ST_SHIFT;
          else          state_d = ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      ST_SHIFT: if (sh_done) state_d = ST_DONE;
`endif
      ST_DONE:  if (bus.out_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    if (accept) result_d = alu_compute(bus.alu_ctrl_i, bus.op_a_i, bus.op_b_i);
`ifndef ALU_FAST_SHIFT_EN
    if ((state_q == ST_SHIFT) && sh_done) result_d = sh_result;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) result_q <= '0;
    else         result_q <= result_d;
  end

  always_comb begin
    bus.in_ready_o  = (state_q == ST_IDLE);
    bus.out_valid_o = (state_q == ST_DONE);
    bus.zero_o      = (state_q == ST_DONE) & (result_q == '0);
    bus.result_o    = result_q;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, randomized ops
// against a behavioural model, backpressure and reset-mid-shift sequences.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int shift_lat(input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]) + 1;
`endif
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd1: return a & b;
      4'd2: return a | b;
      4'd3: return a ^ b;
      4'd4: return a << sh;
      4'd5: return a >> sh;
      4'd6: return $signed(a) >>> sh;
      4'd7: return a - b;
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    return (op >= 4'd4 && op <= 4'd6) ? shift_lat(b) : 1;
  endfunction

  // Issue one request, measure latency, check result/zero, then complete the handshake.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int lat;
    @(negedge clk);
    check({nm, ".in_ready"}, bus.in_ready_o, 1);
    bus.in_valid_i  = 1'b1;
    bus.alu_ctrl_i  = op;
    bus.op_a_i      = a;
    bus.op_b_i      = b;
    bus.out_ready_i = 1'b0;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat = 1;
    while (!bus.out_valid_o && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, ".latency"}, lat, exp_lat);
    check({nm, ".result"}, bus.result_o, exp_r);
    check({nm, ".zero"}, bus.zero_o, (exp_r == 32'd0));
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check({nm, ".drop_valid"}, bus.out_valid_o, 0);
    check({nm, ".back_idle"}, bus.in_ready_o, 1);
  endtask

  vec_t vecs[14];

  initial begin
    int lat;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{"add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1};
    vecs[1]  = '{"sub_eq",    4'b0111, 32'd5,         32'd5,        32'h0000_0000, 1};
    vecs[2]  = '{"slt_neg",   4'b1001, 32'hFFFF_FFFF, 32'd1,        32'h0000_0001, 1};
    vecs[3]  = '{"sltu_big",  4'b1000, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1};
    vecs[4]  = '{"sra_31",    4'b0110, 32'h8000_0000, 32'd31,       32'hFFFF_FFFF, shift_lat(32'd31)};
    vecs[5]  = '{"sll_zero",  4'b0100, 32'h0000_1234, 32'h20,       32'h0000_1234, 1};
    vecs[6]  = '{"code_1111", 4'b1111, 32'd2,         32'd3,        32'h0000_0005, 1};
    vecs[7]  = '{"and",       4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1};
    vecs[8]  = '{"or",        4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1};
    vecs[9]  = '{"xor_same",  4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1};
    vecs[10] = '{"srl_4",     4'b0101, 32'h8000_0000, 32'd4,        32'h0800_0000, shift_lat(32'd4)};
    vecs[11] = '{"sll_31",    4'b0100, 32'h0000_0001, 32'd31,       32'h8000_0000, shift_lat(32'd31)};
    vecs[12] = '{"sra_pos",   4'b0110, 32'h7FFF_FFFF, 32'd1,        32'h3FFF_FFFF, shift_lat(32'd1)};
    vecs[13] = '{"code_1010", 4'b1010, 32'hFFFF_FFFE, 32'd3,        32'h0000_0001, 1};

    bus.in_valid_i  = 1'b0;
    bus.alu_ctrl_i  = 4'd0;
    bus.op_a_i      = '0;
    bus.op_b_i      = '0;
    bus.out_ready_i = 1'b0;

    #12;
    check("rst.in_ready", bus.in_ready_o, 1);
    check("rst.out_valid", bus.out_valid_o, 0);
    check("rst.result", bus.result_o, 0);
    check("rst.zero", bus.zero_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);

    // Backpressure: result held while out_ready_i is low; a new request is ignored.
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.alu_ctrl_i = 4'b0011;
    bus.op_a_i = 32'h0000_0F0F; bus.op_b_i = 32'h0000_00FF;
    @(posedge clk); #1;
    bus.alu_ctrl_i = 4'b0000; bus.op_a_i = 32'd1; bus.op_b_i = 32'd1;
    for (int k = 0; k < 5; k++) begin
      check("bp.valid", bus.out_valid_o, 1);
      check("bp.result", bus.result_o, 32'h0000_0FF0);
      check("bp.zero", bus.zero_o, 0);
      check("bp.in_ready", bus.in_ready_o, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check("bp.release_valid", bus.out_valid_o, 0);
    check("bp.release_idle", bus.in_ready_o, 1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    check("bp.next_valid", bus.out_valid_o, 1);
    check("bp.next_result", bus.result_o, 32'd2);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;

    // Reset in the middle of a long shift.
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.alu_ctrl_i = 4'b0100;
    bus.op_a_i = 32'h0000_0003; bus.op_b_i = 32'd20;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.out_valid", bus.out_valid_o, 0);
    check("rstmid.result", bus.result_o, 0);
    check("rstmid.in_ready", bus.in_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("rstmid.add", 4'b0000, 32'd40, 32'd2, 32'd42, 1);

    // Randomized ops against the behavioural model.
    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      if ($urandom_range(0, 4) == 0) rb = 32'($urandom_range(0, 40));
      run_op("rand", rop, ra, rb, ref_alu(rop, ra, rb), ref_lat(rop, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
